// File: rtl/conv_pixel_tx.sv
// Frame buffer plus raster-order pixel streamer with a valid/ready output
// and sof/eol/eof markers registered alongside each pixel.
module conv_pixel_tx #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              abort,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done,
  output logic              dbg_state
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W:0]   NPIX_EXT = (ADDR_W + 1)'(NPIX);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  // Handshake: a beat is valid && ready at a rising edge. While valid is high
  // and ready is low, data_out and every marker hold their value.
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                sof_q, sof_d;
  logic                eol_q, eol_d;
  logic                eof_q, eof_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [COL_W-1:0]    col_q, col_d, col_n;
  logic [ROW_W-1:0]    row_q, row_d, row_n;
  logic [ADDR_W-1:0]   addr_q, addr_d, rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_ok;
  logic                last_pix;

  logic [DATA_W-1:0]   mem [NPIX];

  assign wr_ok = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < NPIX_EXT);

  // Buffer is not reset; the read below is combinational so a same-edge
  // write to address 0 is seen only by the next frame.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  assign rd_addr  = (state_q == S_IDLE) ? '0 : addr_q + ADDR_W'(1);
  assign rd_data  = mem[rd_addr];
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign col_n    = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
  assign row_n    = (col_q == COL_LAST) ? row_q + ROW_W'(1) : row_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          data_d  = rd_data;
          valid_d = 1'b1;
          sof_d   = 1'b1;
          eol_d   = (IMG_W == 1);
          eof_d   = (NPIX == 1);
          busy_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eol_d   = 1'b0;
          eof_d   = 1'b0;
          busy_d  = 1'b0;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end else if (valid_q && ready) begin
          if (last_pix) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
          end else begin
            data_d  = rd_data;
            sof_d   = 1'b0;
            eol_d   = (col_n == COL_LAST);
            eof_d   = (row_n == ROW_LAST) && (col_n == COL_LAST);
            col_d   = col_n;
            row_d   = row_n;
            addr_d  = rd_addr;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_pixel_tx.sv
// Directed bench for conv_pixel_tx: ramp frame streamed under several ready,
// abort, reset and write-collision scenarios against an expected-pixel queue.
module tb_conv_pixel_tx;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NPIX = W * H;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        abort;
  logic        ready;
  logic [15:0] data_out;
  logic        valid, sof, eol, eof, busy, done, dbg_state;

  int total = 0;
  int bad   = 0;
  int done_cnt;

  logic [15:0] exp_q[$];
  int          idx_q[$];

  conv_pixel_tx dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .abort(abort), .ready(ready),
    .data_out(data_out), .valid(valid), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks (all return at posedge + 1)
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NPIX; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 16'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(16'(i % NPIX));
      idx_q.push_back(i % NPIX);
    end
  endtask

  // scoreboard consumer: pops one expected pixel per beat
  task automatic consume(input bit toggle, input bit restart);
    int cyc = 0;
    int limit;
    int idx;
    logic [15:0] exp_d;
    logic stall_prev = 1'b0;
    logic [19:0] snap = '0;
    limit = idx_q.size() * 4 + 50;
    while (idx_q.size() > 0 && cyc < limit) begin
      ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start = restart && (done === 1'b1);
      if (done === 1'b1) done_cnt++;
      if (stall_prev) begin
        total++;
        if ({data_out, sof, eol, eof, valid} !== snap) begin
          bad++;
          $display("FAIL stall_hold got=%h exp=%h", {data_out, sof, eol, eof, valid}, snap);
        end
      end
      if (valid === 1'b1) begin
        if (ready) begin
          idx   = idx_q.pop_front();
          exp_d = exp_q.pop_front();
          total++;
          if ({data_out, sof, eol, eof, busy} !==
              {exp_d, idx == 0, idx % W == W - 1, idx == NPIX - 1, 1'b1}) begin
            bad++;
            $display("FAIL beat idx=%0d got={data,sof,eol,eof,busy}=%h exp=%h", idx,
                     {data_out, sof, eol, eof, busy},
                     {exp_d, idx == 0, idx % W == W - 1, idx == NPIX - 1, 1'b1});
          end
        end
        stall_prev = !ready;
        snap       = {data_out, sof, eol, eof, valid};
      end else begin
        stall_prev = 1'b0;
      end
      tick();
      cyc++;
    end
    ready = 1'b0;
    start = 1'b0;
    total++;
    if (idx_q.size() != 0) begin
      bad++;
      $display("FAIL beat_timeout left=%0d exp=0", idx_q.size());
    end
    exp_q.delete();
    idx_q.delete();
  endtask

  task automatic check_done_cycle(input string name, input logic [15:0] last_d);
    total++;
    if ({done, valid, busy, sof, eol, eof, dbg_state, data_out} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_d}) begin
      bad++;
      $display("FAIL %s done_cycle got=%h exp=%h", name,
               {done, valid, busy, sof, eol, eof, dbg_state, data_out},
               {7'b1000000, last_d});
    end
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({data_out, valid, sof, eol, eof, busy, done, dbg_state} !== 23'd0) begin
      bad++;
      $display("FAIL reset got=%h exp=0", {data_out, valid, sof, eol, eof, busy, done, dbg_state});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_rate();
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL pre_start_valid got=%b exp=0", valid); end
    start_frame();
    total++;
    if ({valid, sof, busy, data_out} !== {3'b111, 16'd0}) begin
      bad++;
      $display("FAIL start_latency got=%h exp=%h", {valid, sof, busy, data_out}, {3'b111, 16'd0});
    end
    push_beats(NPIX);
    consume(1'b0, 1'b0);
    check_done_cycle("full_rate", 16'd783);
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", done); end
  endtask

  task automatic test_ready_toggle();
    start_frame();
    push_beats(NPIX);
    consume(1'b1, 1'b0);
    check_done_cycle("toggle", 16'd783);
    tick();
  endtask

  task automatic test_write_rules();
    do_write(10'd800, 16'h1234);
    start = 1'b1; wr_en = 1'b1; wr_addr = 10'd0; wr_data = 16'hAAAA;
    tick();
    start = 1'b0; wr_en = 1'b0;
    total++;
    if ({valid, sof, data_out} !== {2'b11, 16'd0}) begin
      bad++;
      $display("FAIL read_before_write got=%h exp=%h", {valid, sof, data_out}, {2'b11, 16'd0});
    end
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 16'hBEEF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    total++;
    if ({valid, sof, data_out} !== {2'b11, 16'd0}) begin
      bad++;
      $display("FAIL restart_ignored got=%h exp=%h", {valid, sof, data_out}, {2'b11, 16'd0});
    end
    push_beats(NPIX);
    consume(1'b0, 1'b0);
    check_done_cycle("write_rules", 16'd783);
    tick();
    start_frame();
    total++;
    if (data_out !== 16'hAAAA) begin
      bad++;
      $display("FAIL pixel0_written got=%h exp=aaaa", data_out);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    do_write(10'd0, 16'd0);
  endtask

  task automatic test_abort();
    int seen_done = 0;
    start_frame();
    push_beats(100);
    consume(1'b0, 1'b0);
    total++;
    if (data_out !== 16'd100) begin bad++; $display("FAIL abort_pre got=%0d exp=100", data_out); end
    ready = 1'b1; abort = 1'b1;
    tick();
    ready = 1'b0; abort = 1'b0;
    total++;
    if ({valid, sof, eol, eof, busy, done, dbg_state} !== 7'd0) begin
      bad++;
      $display("FAIL abort_outputs got=%b exp=0000000", {valid, sof, eol, eof, busy, done, dbg_state});
    end
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    total++;
    if (seen_done != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    start_frame();
    total++;
    if ({valid, sof, data_out} !== {2'b11, 16'd0}) begin
      bad++;
      $display("FAIL abort_restart got=%h exp=%h", {valid, sof, data_out}, {2'b11, 16'd0});
    end
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if ({valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL idle_abort_no_effect got=%b exp=11", {valid, busy});
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_async_reset();
    start_frame();
    push_beats(50);
    consume(1'b0, 1'b0);
    total++;
    if (data_out !== 16'd50) begin bad++; $display("FAIL reset_pre got=%0d exp=50", data_out); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({data_out, valid, sof, eol, eof, busy, done, dbg_state} !== 23'd0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {data_out, valid, sof, eol, eof, busy, done, dbg_state});
    end
    tick();
    reset_n = 1'b1;
    tick();
    start_frame();
    push_beats(NPIX);
    consume(1'b0, 1'b0);
    check_done_cycle("after_reset", 16'd783);
    tick();
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    start_frame();
    push_beats(2 * NPIX);
    consume(1'b0, 1'b1);
    if (done === 1'b1) done_cnt++;
    check_done_cycle("back_to_back", 16'd783);
    total++;
    if (done_cnt != 2) begin bad++; $display("FAIL done_pulses got=%0d exp=2", done_cnt); end
    tick();
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; abort = 1'b0; ready = 1'b0;
    test_reset();
    load_ramp();
    test_full_rate();
    test_ready_toggle();
    test_write_rules();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
